// File: rtl/mips_control_unit_pkg.sv
// Shared types for the multi-cycle MIPS control path: instruction fields, ALU codes, FSM states, mux selects.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_control_unit_pkg;

    localparam int MIPS_OP_WIDTH    = 6;
    localparam int MIPS_FUNCT_WIDTH = 6;
    localparam int ALU_OP_WIDTH     = 3;

    typedef enum logic [MIPS_OP_WIDTH-1:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } mips_op_e;

    typedef enum logic [MIPS_FUNCT_WIDTH-1:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } mips_funct_e;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_RTEXEC   = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_ADDIEXEC = 4'd8,
        ST_ADDIWB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } mips_ctrl_state_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        ALUB_REGB    = 2'd0,
        ALUB_FOUR    = 2'd1,
        ALUB_IMM     = 2'd2,
        ALUB_IMM_SH2 = 2'd3
    } alu_src_b_e;

    // Plain vectors so the whole bundle can be cleared with a single '0.
    typedef struct packed {
        logic                    mem_req;
        logic                    mem_we;
        logic                    i_or_d;
        logic                    ir_we;
        logic                    pc_we;
        logic [1:0]              pc_src;
        logic                    alu_src_a;
        logic [1:0]              alu_src_b;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    reg_we;
        logic                    reg_dst;
        logic                    mem_to_reg;
        logic                    instr_done;
    } ctrl_t;

    function automatic logic op_legal(mips_op_e op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and status in, enables and mux selects out.
// Purely wiring; all timing lives in the control FSM.
interface mips_control_unit_if;
    import mips_control_unit_pkg::*;

    mips_op_e                op_i;
    mips_funct_e             funct_i;
    logic                    zero_i;
    logic                    mem_ready_i;

    logic                    mem_req_o;
    logic                    mem_we_o;
    logic                    i_or_d_o;
    logic                    ir_we_o;
    logic                    pc_we_o;
    logic [1:0]              pc_src_o;
    logic                    alu_src_a_o;
    logic [1:0]              alu_src_b_o;
    logic [ALU_OP_WIDTH-1:0] alu_op_o;
    logic                    reg_we_o;
    logic                    reg_dst_o;
    logic                    mem_to_reg_o;
    logic                    instr_done_o;
    logic                    illegal_o;

    modport master (
        input  op_i, funct_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, i_or_d_o, ir_we_o, pc_we_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, reg_we_o, reg_dst_o,
               mem_to_reg_o, instr_done_o, illegal_o
    );

    modport slave (
        output op_i, funct_i, zero_i, mem_ready_i,
        input  mem_req_o, mem_we_o, i_or_d_o, ir_we_o, pc_we_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, reg_we_o, reg_dst_o,
               mem_to_reg_o, instr_done_o, illegal_o
    );

endinterface

// File: rtl/mips_alu_decoder.sv
// R-type funct -> ALU control code plus a valid bit; combinational, zero latency, no flow control.
module mips_alu_decoder
    import mips_control_unit_pkg::*;
(
    input  mips_funct_e funct_i,
    output alu_ctrl_e   alu_ctrl_o,
    output logic        valid_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multi-cycle MIPS main control FSM; 3-5 cycles per instruction with ready memory.
// Memory request states hold mem_req and address/control stable until mem_ready_i.
module mips_control_unit
    import mips_control_unit_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    mips_control_unit_if.master bus
);

    mips_ctrl_state_e state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             is_sw_q, is_sw_d;
    alu_ctrl_e        rt_alu_op;
    logic             rt_valid;
    ctrl_t            ctrl;

    mips_alu_decoder u_alu_dec (
        .funct_i    (bus.funct_i),
        .alu_ctrl_o (rt_alu_op),
        .valid_o    (rt_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            is_sw_q   <= is_sw_d;
        end
    end

    // Load vs store is captured in DECODE so the opcode is only looked at there.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        is_sw_d   = is_sw_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready_i) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                is_sw_d = (bus.op_i == OP_SW);
                case (bus.op_i)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTEXEC;
                    OP_ADDI:      state_d = ST_ADDIEXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR:   state_d = is_sw_q ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (bus.mem_ready_i) state_d = ST_MEMWB;
            end
            ST_MEMWR: begin
                if (bus.mem_ready_i) state_d = ST_FETCH;
            end
            ST_RTEXEC: begin
                if (rt_valid) begin
                    state_d = ST_ALUWB;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_ADDIEXEC: state_d = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_we     = bus.mem_ready_i;
                ctrl.pc_we     = bus.mem_ready_i;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = ALUB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = ~op_legal(bus.op_i);
            end
            ST_MEMADR, ST_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready_i;
            end
            ST_RTEXEC: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = ALUB_REGB;
                ctrl.alu_op     = rt_alu_op;
                ctrl.instr_done = ~rt_valid;
            end
            ST_ALUWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = ALUB_REGB;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.pc_we      = bus.zero_i;
                ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.pc_we      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!rst_n) ctrl = '0;
    end

    assign bus.mem_req_o    = ctrl.mem_req;
    assign bus.mem_we_o     = ctrl.mem_we;
    assign bus.i_or_d_o     = ctrl.i_or_d;
    assign bus.ir_we_o      = ctrl.ir_we;
    assign bus.pc_we_o      = ctrl.pc_we;
    assign bus.pc_src_o     = ctrl.pc_src;
    assign bus.alu_src_a_o  = ctrl.alu_src_a;
    assign bus.alu_src_b_o  = ctrl.alu_src_b;
    assign bus.alu_op_o     = ctrl.alu_op;
    assign bus.reg_we_o     = ctrl.reg_we;
    assign bus.reg_dst_o    = ctrl.reg_dst;
    assign bus.mem_to_reg_o = ctrl.mem_to_reg;
    assign bus.instr_done_o = ctrl.instr_done;
    assign bus.illegal_o    = illegal_q & rst_n;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed per-cycle vectors for the MIPS control FSM, checked through an expectation queue by a negedge monitor.
module tb_mips_control_unit;
    import mips_control_unit_pkg::*;

    localparam logic [5:0] O_RT = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                           O_ADDI = 6'b001000, O_LW = 6'b100011, O_SW = 6'b101011,
                           O_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b111111;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    mips_control_unit_if bus_if ();

    mips_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    // {mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src[1:0], alu_src_a, alu_src_b[1:0], alu_op[2:0], reg_we, reg_dst, mem_to_reg, instr_done, illegal}
    logic [17:0] act;
    assign act = {bus_if.mem_req_o, bus_if.mem_we_o, bus_if.i_or_d_o, bus_if.ir_we_o, bus_if.pc_we_o,
                  bus_if.pc_src_o, bus_if.alu_src_a_o, bus_if.alu_src_b_o, bus_if.alu_op_o,
                  bus_if.reg_we_o, bus_if.reg_dst_o, bus_if.mem_to_reg_o, bus_if.instr_done_o,
                  bus_if.illegal_o};

    function automatic logic [17:0] pk(input bit mreq, input bit mwe, input bit iod, input bit irwe,
                                       input bit pcwe, input logic [1:0] pcs, input bit a,
                                       input logic [1:0] b, input logic [2:0] op, input bit rwe,
                                       input bit rdst, input bit m2r, input bit done, input bit ill);
        return {mreq, mwe, iod, irwe, pcwe, pcs, a, b, op, rwe, rdst, m2r, done, ill};
    endfunction

    function automatic logic [17:0] e_zero();
        return 18'd0;
    endfunction
    function automatic logic [17:0] e_fetch(input bit rdy, input bit ill);
        return pk(1, 0, 0, rdy, rdy, 2'd0, 0, 2'd1, 3'd0, 0, 0, 0, 0, ill);
    endfunction
    function automatic logic [17:0] e_dec(input bit ill, input bit done);
        return pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 3'd0, 0, 0, 0, done, ill);
    endfunction
    function automatic logic [17:0] e_imm(input bit ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 3'd0, 0, 0, 0, 0, ill);
    endfunction
    function automatic logic [17:0] e_memrd(input bit ill);
        return pk(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 0, 0, 0, ill);
    endfunction
    function automatic logic [17:0] e_memwb(input bit ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 1, 0, 1, 1, ill);
    endfunction
    function automatic logic [17:0] e_memwr(input bit rdy, input bit ill);
        return pk(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 0, 0, rdy, ill);
    endfunction
    function automatic logic [17:0] e_rt(input logic [2:0] op, input bit done, input bit ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, op, 0, 0, 0, done, ill);
    endfunction
    function automatic logic [17:0] e_aluwb(input bit ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 1, 1, 0, 1, ill);
    endfunction
    function automatic logic [17:0] e_addiwb(input bit ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 1, 0, 0, 1, ill);
    endfunction
    function automatic logic [17:0] e_br(input bit z, input bit ill);
        return pk(0, 0, 0, 0, z, 2'd1, 1, 2'd0, 3'd1, 0, 0, 0, 1, ill);
    endfunction
    function automatic logic [17:0] e_jmp(input bit ill);
        return pk(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 3'd0, 0, 0, 0, 1, ill);
    endfunction

    task automatic cyc(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input bit rdy, input bit rst, input logic [17:0] e);
        exp_t x;
        bus_if.op_i        = mips_op_e'(op);
        bus_if.funct_i     = mips_funct_e'(fn);
        bus_if.zero_i      = z;
        bus_if.mem_ready_i = rdy;
        rst_n              = rst;
        x.name = name;
        x.v    = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if (act !== cur.v) begin
                errors++;
                $display("FAIL %s: got %b want %b", cur.name, act, cur.v);
            end
        end
    end

    logic [5:0] rt_fn [4];
    logic [2:0] rt_op [4];

    initial begin
        rst_n              = 1'b0;
        bus_if.op_i        = mips_op_e'(O_RT);
        bus_if.funct_i     = mips_funct_e'(F_ADD);
        bus_if.zero_i      = 1'b0;
        bus_if.mem_ready_i = 1'b1;
        rt_fn = '{F_ADD, F_AND, F_OR, F_SLT};
        rt_op = '{3'd0, 3'd2, 3'd3, 3'd4};
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) cyc("reset", O_RT, F_ADD, 0, 1, 0, e_zero());

        cyc("sub_fetch", O_RT, F_SUB, 0, 1, 1, e_fetch(1, 0));
        cyc("sub_dec",   O_RT, F_SUB, 0, 1, 1, e_dec(0, 0));
        cyc("sub_exec",  O_RT, F_SUB, 0, 1, 1, e_rt(3'd1, 0, 0));
        cyc("sub_wb",    O_RT, F_SUB, 0, 1, 1, e_aluwb(0));

        cyc("lw_fetch", O_LW, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("lw_dec",   O_LW, F_ADD, 0, 1, 1, e_dec(0, 0));
        cyc("lw_adr",   O_LW, F_ADD, 0, 1, 1, e_imm(0));
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", O_LW, F_ADD, 0, 0, 1, e_memrd(0));
        cyc("lw_rd_go", O_LW, F_ADD, 0, 1, 1, e_memrd(0));
        cyc("lw_wb",    O_LW, F_ADD, 0, 1, 1, e_memwb(0));

        cyc("sw_fetch", O_SW, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("sw_dec",   O_SW, F_ADD, 0, 1, 1, e_dec(0, 0));
        cyc("sw_adr",   O_SW, F_ADD, 0, 1, 1, e_imm(0));
        for (int i = 0; i < 3; i++) cyc("sw_wr_wait", O_SW, F_ADD, 0, 0, 1, e_memwr(0, 0));
        cyc("sw_wr_go", O_SW, F_ADD, 0, 1, 1, e_memwr(1, 0));

        cyc("beq1_fetch", O_BEQ, F_ADD, 1, 1, 1, e_fetch(1, 0));
        cyc("beq1_dec",   O_BEQ, F_ADD, 1, 1, 1, e_dec(0, 0));
        cyc("beq1_br",    O_BEQ, F_ADD, 1, 1, 1, e_br(1, 0));
        cyc("beq0_fetch", O_BEQ, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("beq0_dec",   O_BEQ, F_ADD, 0, 1, 1, e_dec(0, 0));
        cyc("beq0_br",    O_BEQ, F_ADD, 0, 1, 1, e_br(0, 0));

        cyc("j_fetch", O_J, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("j_dec",   O_J, F_ADD, 0, 1, 1, e_dec(0, 0));
        cyc("j_jump",  O_J, F_ADD, 0, 1, 1, e_jmp(0));

        cyc("addi_fetch_stall", O_ADDI, F_ADD, 0, 0, 1, e_fetch(0, 0));
        cyc("addi_fetch",       O_ADDI, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("addi_dec",         O_ADDI, F_ADD, 0, 1, 1, e_dec(0, 0));
        cyc("addi_exec",        O_ADDI, F_ADD, 0, 1, 1, e_imm(0));
        cyc("addi_wb",          O_ADDI, F_ADD, 0, 1, 1, e_addiwb(0));

        for (int i = 0; i < 4; i++) begin
            cyc("rt_fetch", O_RT, rt_fn[i], 0, 1, 1, e_fetch(1, 0));
            cyc("rt_dec",   O_RT, rt_fn[i], 0, 1, 1, e_dec(0, 0));
            cyc("rt_exec",  O_RT, rt_fn[i], 0, 1, 1, e_rt(rt_op[i], 0, 0));
            cyc("rt_wb",    O_RT, rt_fn[i], 0, 1, 1, e_aluwb(0));
        end

        cyc("badop_fetch", O_BAD, F_ADD, 0, 1, 1, e_fetch(1, 0));
        cyc("badop_dec",   O_BAD, F_ADD, 0, 1, 1, e_dec(0, 1));
        cyc("badfn_fetch", O_RT, F_BAD, 0, 1, 1, e_fetch(1, 1));
        cyc("badfn_dec",   O_RT, F_BAD, 0, 1, 1, e_dec(1, 0));
        cyc("badfn_exec",  O_RT, F_BAD, 0, 1, 1, e_rt(3'd0, 1, 1));
        cyc("sticky_fetch", O_RT, F_AND, 0, 1, 1, e_fetch(1, 1));
        cyc("sticky_dec",   O_RT, F_AND, 0, 1, 1, e_dec(1, 0));
        cyc("rst_mid_exec", O_RT, F_AND, 0, 1, 0, e_zero());
        cyc("post_rst_fetch", O_RT, F_OR, 0, 1, 1, e_fetch(1, 0));
        cyc("post_rst_dec",   O_RT, F_OR, 0, 1, 1, e_dec(0, 0));
        cyc("post_rst_exec",  O_RT, F_OR, 0, 1, 1, e_rt(3'd3, 0, 0));
        cyc("post_rst_wb",    O_RT, F_OR, 0, 1, 1, e_aluwb(0));

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
